// File: rtl/dac_sched_pkg.sv
// dac_pkg: shared constants for the DAC scheduler and its arbiter.
// Command nibbles, addresses, FSM encoding and the DAC code width.
package dac_pkg;

    localparam int DW = 12;

    localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
    localparam logic [3:0] CMD_POWER_DOWN   = 4'b0100;

    localparam logic [3:0] ADDR_A   = 4'h0;
    localparam logic [3:0] ADDR_B   = 4'h1;
    localparam logic [3:0] ADDR_C   = 4'h2;
    localparam logic [3:0] ADDR_D   = 4'h3;
    localparam logic [3:0] ADDR_ALL = 4'hF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    function automatic logic [3:0] onehot4(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

endpackage

// File: rtl/dac_sched_rr_arb.sv
// dac_rr_arb: 4-way round-robin pick, searching from ptr+1 upward.
// Purely combinational; the caller owns the pointer register.
module dac_rr_arb (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] gnt,
    output logic       vld
);

    always_comb begin
        gnt = ptr;
        vld = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (!vld && req[ptr + 2'(i)]) begin
                gnt = ptr + 2'(i);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dac_sched.sv
// dac_sched: round-robin sharing of one serial DAC driver by four channels.
// Optional broadcast to all channels with `define DAC_SCHED_BROADCAST_EN.
module dac_sched
    import dac_pkg::*;
#(
    parameter int         NCH     = 4,
    parameter logic [3:0] CMD     = CMD_WRITE_UPDATE,
    parameter int         TIMEOUT = 4096
) (
    input  logic          CLK50MHZ,
    input  logic          RST,
    input  logic          wr_en,
    input  logic [1:0]    wr_chan,
    input  logic [DW-1:0] wr_data,
`ifdef DAC_SCHED_BROADCAST_EN
    input  logic          bc_en,
    input  logic [DW-1:0] bc_data,
`endif
    output logic [DW-1:0] data,
    output logic [3:0]    address,
    output logic [3:0]    command,
    output logic          dactrig,
    input  logic          dacdone,
    output logic [3:0]    pending,
    output logic          busy,
    output logic          err,
    output logic [7:0]    LED
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    logic [1:0]    state;
    logic [1:0]    rr;
    logic [1:0]    gnt;
    logic          gvld;
    logic          granted;
    logic          go;
    logic          go_ch;
    logic          bc_go;
    logic          bc_fly;
    logic          tmo;
    logic [TW-1:0] timer;
    logic [3:0]    pend;
    logic [3:0]    pend_nxt;
    logic [DW-1:0] shadow [NCH];
    logic [DW-1:0] go_data;
    logic [3:0]    go_addr;

    dac_rr_arb u_arb (
        .req (pend),
        .ptr (rr),
        .gnt (gnt),
        .vld (gvld)
    );

`ifdef DAC_SCHED_BROADCAST_EN
    logic          bc_pend;
    logic [DW-1:0] bc_val;

    assign bc_go   = (state == ST_IDLE) && bc_pend;
    assign go_data = bc_pend ? bc_val : shadow[gnt];
    assign go_addr = bc_pend ? ADDR_ALL : {2'b00, gnt};

    // bc_fly marks a broadcast in flight so a timeout re-queues it.
    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            bc_pend <= 1'b0;
            bc_fly  <= 1'b0;
            bc_val  <= '0;
        end else begin
            if (bc_go)
                bc_fly <= 1'b1;
            else if (go_ch)
                bc_fly <= 1'b0;
            if (bc_go)
                bc_pend <= 1'b0;
            else if (tmo && bc_fly)
                bc_pend <= 1'b1;
            if (bc_en) begin
                bc_pend <= 1'b1;
                bc_val  <= bc_data;
            end
        end
    end
`else
    assign bc_go   = 1'b0;
    assign bc_fly  = 1'b0;
    assign go_data = shadow[gnt];
    assign go_addr = {2'b00, gnt};
`endif

    assign go_ch = (state == ST_IDLE) && gvld && !bc_go;
    assign go    = go_ch || bc_go;
    assign tmo   = (state == ST_ISSUE) && !dacdone && (timer == TMAX);

    // A write on the same edge always wins over grant/broadcast clears.
    always_comb begin
        pend_nxt = pend;
        if (go_ch)
            pend_nxt[gnt] = 1'b0;
        if (bc_go)
            pend_nxt = '0;
        if (tmo && !bc_fly)
            pend_nxt[rr] = 1'b1;
        if (wr_en)
            pend_nxt[wr_chan] = 1'b1;
    end

    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            state   <= ST_IDLE;
            dactrig <= 1'b0;
            data    <= '0;
            address <= '0;
            command <= '0;
            pend    <= '0;
            rr      <= 2'd3;
            granted <= 1'b0;
            timer   <= '0;
            err     <= 1'b0;
            for (int i = 0; i < NCH; i++)
                shadow[i] <= '0;
        end else begin
            pend <= pend_nxt;
`ifdef DAC_SCHED_BROADCAST_EN
            if (bc_go)
                for (int i = 0; i < NCH; i++)
                    shadow[i] <= bc_val;
`endif
            if (wr_en)
                shadow[wr_chan] <= wr_data;
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        data    <= go_data;
                        address <= go_addr;
                        command <= CMD;
                        dactrig <= 1'b1;
                        timer   <= '0;
                        state   <= ST_ISSUE;
                    end
                    if (go_ch) begin
                        rr      <= gnt;
                        granted <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (dacdone) begin
                        dactrig <= 1'b0;
                        state   <= ST_GAP;
                    end else if (timer == TMAX) begin
                        dactrig <= 1'b0;
                        err     <= 1'b1;
                        state   <= ST_GAP;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                ST_GAP:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign pending = pend;
    assign busy    = dactrig;
    assign LED     = {pend, granted ? onehot4(rr) : 4'b0000};

endmodule

// File: tb/tb_dac_sched.sv
// tb_dac_sched: scoreboarded bench for dac_sched with an auto-acking driver.
// Broadcast sequence runs only when DAC_SCHED_BROADCAST_EN is defined.
module tb_dac_sched;
    import dac_pkg::*;

    localparam int TMO = 4096;

    logic        CLK50MHZ = 1'b0;
    logic        RST      = 1'b1;
    logic        wr_en    = 1'b0;
    logic [1:0]  wr_chan  = 2'd0;
    logic [11:0] wr_data  = 12'h000;
    logic        dacdone  = 1'b0;
`ifdef DAC_SCHED_BROADCAST_EN
    logic        bc_en    = 1'b0;
    logic [11:0] bc_data  = 12'h000;
`endif
    logic [11:0] data;
    logic [3:0]  address;
    logic [3:0]  command;
    logic        dactrig;
    logic [3:0]  pending;
    logic        busy;
    logic        err;
    logic [7:0]  LED;

    dac_sched #(.TIMEOUT(TMO)) dut (
        .CLK50MHZ (CLK50MHZ),
        .RST      (RST),
        .wr_en    (wr_en),
        .wr_chan  (wr_chan),
        .wr_data  (wr_data),
`ifdef DAC_SCHED_BROADCAST_EN
        .bc_en    (bc_en),
        .bc_data  (bc_data),
`endif
        .data     (data),
        .address  (address),
        .command  (command),
        .dactrig  (dactrig),
        .dacdone  (dacdone),
        .pending  (pending),
        .busy     (busy),
        .err      (err),
        .LED      (LED)
    );

    always #10 CLK50MHZ = ~CLK50MHZ;

    typedef struct {
        logic [1:0]  chan;
        logic [11:0] val;
        logic [3:0]  exp_addr;
        logic [11:0] exp_data;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          rises  = 0;
    int          hi_cnt = 0;
    bit          ack_en = 1'b1;
    logic        prev_trig = 1'b0;
    logic [19:0] sb [$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [11:0] v);
        sb.push_back({a, CMD_WRITE_UPDATE, v});
    endtask

    task automatic sync();
        @(posedge CLK50MHZ);
        #1;
    endtask

    task automatic wr(input logic [1:0] c, input logic [11:0] v);
        wr_en   = 1'b1;
        wr_chan = c;
        wr_data = v;
        @(posedge CLK50MHZ);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_rise();
        int n = 0;
        while (dactrig !== 1'b1 && n < 10000) begin
            @(negedge CLK50MHZ);
            n++;
        end
        check("rise_bound", 32'(n < 10000), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        int stable = 0;
        while (stable < 3 && n < 20000) begin
            @(negedge CLK50MHZ);
            n++;
            if (dactrig === 1'b0 && pending === 4'b0000)
                stable++;
            else
                stable = 0;
        end
        check("idle_bound", 32'(n < 20000), 32'd1);
        sync();
    endtask

    // Each rising edge of dactrig must match the oldest queued transaction.
    always @(negedge CLK50MHZ) begin
        if (dactrig === 1'b1 && prev_trig !== 1'b1) begin
            rises++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_txn actual=%0h required=none",
                         {address, command, data});
            end else begin
                check("txn", 32'({address, command, data}),
                      32'(sb.pop_front()));
            end
        end
        prev_trig = dactrig;
    end

    // Driver model: ack 20 cycles after dactrig rises, when enabled.
    initial begin
        forever begin
            @(posedge CLK50MHZ);
            #1;
            dacdone = 1'b0;
            if (ack_en && dactrig === 1'b1) begin
                if (hi_cnt == 19) begin
                    dacdone = 1'b1;
                    hi_cnt  = 0;
                end else begin
                    hi_cnt++;
                end
            end else begin
                hi_cnt = 0;
            end
        end
    end

    initial begin
        vec_t tbl [8];
        int   n;
        int   cnt;
        int   r0;

        tbl[0] = '{2'd3, 12'hA33, ADDR_D, 12'hA33};
        tbl[1] = '{2'd1, 12'hB11, ADDR_A, 12'hC00};
        tbl[2] = '{2'd0, 12'hC00, ADDR_B, 12'hB11};
        tbl[3] = '{2'd2, 12'hD22, ADDR_C, 12'hD22};
        tbl[4] = '{2'd0, 12'hFFF, ADDR_A, 12'hFFF};
        tbl[5] = '{2'd3, 12'h000, ADDR_B, 12'h5A5};
        tbl[6] = '{2'd1, 12'h5A5, ADDR_C, 12'h001};
        tbl[7] = '{2'd2, 12'h001, ADDR_D, 12'h000};

        repeat (3) @(posedge CLK50MHZ);
        @(negedge CLK50MHZ);
        check("rst_dactrig", 32'(dactrig), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_address", 32'(address), 32'd0);
        check("rst_command", 32'(command), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_led", 32'(LED), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        sync();
        RST = 1'b0;
        sync();

        push(ADDR_C, 12'h3FF);
        wr(2'd2, 12'h3FF);
        @(negedge CLK50MHZ);
        check("t1_trig_lo", 32'(dactrig), 32'd0);
        check("t1_pend", 32'(pending), 32'h4);
        @(negedge CLK50MHZ);
        check("t1_trig_hi", 32'(dactrig), 32'd1);
        check("t1_addr", 32'(address), 32'h2);
        check("t1_cmd", 32'(command), 32'h3);
        check("t1_data", 32'(data), 32'h3FF);
        check("t1_busy", 32'(busy), 32'd1);
        n = 0;
        while (dacdone !== 1'b1 && n < 100) begin
            @(negedge CLK50MHZ);
            n++;
        end
        check("t1_ack_bound", 32'(n < 100), 32'd1);
        check("t1_hold", 32'({dactrig, data}), 32'h13FF);
        @(negedge CLK50MHZ);
        check("t1_trig_drop", 32'(dactrig), 32'd0);
        check("t1_pend_clr", 32'(pending), 32'd0);
        check("t1_led", 32'(LED), 32'h04);
        wait_idle();

        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++)
                push(tbl[4*b+i].exp_addr, tbl[4*b+i].exp_data);
            for (int i = 0; i < 4; i++)
                wr(tbl[4*b+i].chan, tbl[4*b+i].val);
            wait_idle();
            check("batch_led_rr", 32'(LED[3:0]),
                  32'(onehot4(tbl[4*b+3].exp_addr[1:0])));
        end

        push(ADDR_D, 12'h3A1);
        push(ADDR_D, 12'h3B2);
        wr(2'd3, 12'h3A1);
        wr(2'd3, 12'h3B2);
        wait_idle();

        push(ADDR_A, 12'h0EE);
        wr(2'd0, 12'h0EE);
        wait_rise();
        sync();
        wr(2'd1, 12'h100);
        wr(2'd1, 12'h200);
        push(ADDR_B, 12'h200);
        wait_idle();

        ack_en = 1'b0;
        push(ADDR_A, 12'h777);
        push(ADDR_A, 12'h777);
        wr(2'd0, 12'h777);
        wait_rise();
        cnt = 0;
        while (dactrig === 1'b1 && cnt < TMO + 10) begin
            cnt++;
            @(negedge CLK50MHZ);
        end
        check("tmo_len", 32'(cnt), 32'(TMO));
        check("tmo_trig", 32'(dactrig), 32'd0);
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_retry_pend", 32'(pending), 32'h1);
        ack_en = 1'b1;
        wait_idle();
        check("tmo_err_sticky", 32'(err), 32'd1);

        push(ADDR_C, 12'h222);
        wr(2'd2, 12'h222);
        wait_rise();
        sync();
        wr(2'd1, 12'h111);
        wr(2'd3, 12'h333);
        check("rst_mid_pend", 32'(pending), 32'hA);
        RST = 1'b1;
        @(posedge CLK50MHZ);
        @(negedge CLK50MHZ);
        check("rst_mid_trig", 32'(dactrig), 32'd0);
        check("rst_mid_pend0", 32'(pending), 32'd0);
        check("rst_mid_err", 32'(err), 32'd0);
        check("rst_mid_led", 32'(LED), 32'd0);
        sync();
        RST = 1'b0;
        r0 = rises;
        repeat (40) @(negedge CLK50MHZ);
        check("rst_quiet", 32'(rises - r0), 32'd0);
        check("rst_quiet_pend", 32'(pending), 32'd0);
        sync();

`ifdef DAC_SCHED_BROADCAST_EN
        push(ADDR_B, 12'h1C1);
        wr(2'd1, 12'h1C1);
        wait_rise();
        sync();
        wr(2'd0, 12'h0C0);
        wr(2'd2, 12'h2C2);
        bc_en   = 1'b1;
        bc_data = 12'h800;
        sync();
        bc_en = 1'b0;
        push(ADDR_ALL, 12'h800);
        wait_idle();
        check("bc_pend", 32'(pending), 32'd0);
        check("bc_led_rr", 32'(LED[3:0]), 32'h2);
`endif

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dac_sched.md
Name: dac_sched

Overview:
- Round-robin scheduler that shares the single serial DAC transmitter among four channel requesters.
- Holds a 12-bit shadow value and a pending flag per DAC channel.
- Issues one write-and-update transaction at a time to the DAC driver over the data/address/command/dactrig/dacdone handshake.
- Sits between application logic (waveform generators, switches) and the DAC driver; replaces the fixed-value test sequencer.

Parameters:
- NCH, 4, number of channels; fixed at 4 (DAC channels A-D), channel index = DAC address.
- CMD, 4'b0011, command nibble driven for every per-channel write (write and update n).
- TIMEOUT, 4096, cycles to wait for dacdone before aborting a transaction; minimum 2.

Ports:
- CLK50MHZ  in  1  system clock, 50 MHz.
- RST  in  1  reset; synchronous, active-high.
- wr_en  in  1  write strobe, one cycle per value.
- wr_chan  in  2  target channel of the write.
- wr_data  in  12  value for the target channel.
- data  out  12  DAC code to the driver, stable while dactrig is high.
- address  out  4  DAC address to the driver.
- command  out  4  DAC command to the driver.
- dactrig  out  1  transaction request level to the driver.
- dacdone  in  1  one-cycle completion pulse from the driver.
- pending  out  4  per-channel pending flags.
- busy  out  1  high while dactrig is high.
- err  out  1  sticky timeout flag.
- LED  out  8  debug: {pending, one-hot of last channel granted}.

Behaviour:
- Reset (synchronous, RST high at an edge): dactrig=0, data=0, address=0, command=0, pending=0, shadows=0, err=0, LED=0, state=IDLE, rr pointer=3 (channel 0 wins first).
- Write: on a wr_en edge, shadow[wr_chan]<=wr_data and pending[wr_chan]<=1.
  - Writing a channel that is already pending overwrites the value (coalescing); only the last value is sent.
- IDLE: if any pending bit is set, grant the first pending channel searching from rr+1 modulo 4. On the same edge:
  - data<=shadow[g], address<={2'b00,g}, command<=CMD, dactrig<=1, pending[g]<=0, rr<=g, timer<=0; go to ISSUE.
  - Latency: wr_en sampled at edge k gives dactrig high after edge k+1 if the block is idle.
- ISSUE: data, address and command are held constant, and dactrig is held high.
  - On dacdone=1: dactrig<=0, go to GAP.
  - If timer reaches TIMEOUT-1 without dacdone: dactrig<=0, err<=1, pending[rr]<=1 (retried later), go to GAP.
- GAP: exactly one cycle with dactrig low, then IDLE. This guarantees a rising edge for each transaction.
- Simultaneous events:
  - A write to the granted channel on the grant edge sets pending again; the write wins over the clear, and the new value is sent in a later transaction.
  - A write during ISSUE updates the shadow only; the in-flight data is unaffected.
  - dacdone outside ISSUE is ignored.
  - A timeout and dacdone on the same edge count as done; err is not set.
- Fairness: with all four channels pending continuously, the grant order is 0,1,2,3,0,...
- RST mid-transaction: dactrig drops on the next edge, all pending flags are lost, and err clears.
- busy = dactrig.
- LED[7:4] = pending. LED[3:0] = one-hot of rr, zero after reset until the first grant.

Optional Feature:
- DAC_SCHED_BROADCAST_EN: adds inputs bc_en (1) and bc_data (12).
  - bc_en latches bc_data and sets bc_pending.
  - In IDLE, bc_pending has priority over all channels and issues address 4'b1111 with CMD and bc_data.
  - On grant it clears bc_pending, all per-channel pending bits, and loads bc_data into all shadows. A channel write on that same edge still sets its pending bit.
- Without the macro: ports absent, no broadcast logic; address[3:2] is always 0.

Decomposition:
- Shared package dac_pkg:
  - command constants: CMD_WRITE_UPDATE=4'b0011, CMD_POWER_DOWN=4'b0100.
  - ADDR_ALL=4'b1111 and per-channel address constants A-D.
  - state encoding IDLE/ISSUE/GAP.
  - data width constant 12.
- One sub-module: dac_rr_arb (4-way round-robin, pending+pointer in, grant index and valid out).
- Timer and shadow registers stay in the top.

Test Plan:
- Reset, then wr_en chan=2 data=12'h3FF; driver acks dacdone 20 cycles after dactrig rises.
  - Required: dactrig high one edge after the write edge, with address=4'h2, command=4'h3, data=12'h3FF.
  - dactrig low the edge after dacdone, then pending=0.
- Writes to channels 3,1,0,2 in consecutive cycles while idle.
  - Required: transactions in order 3,0,1,2 (3 granted first since idle, then rr from 3); each separated by at least one dactrig-low cycle.
- Two writes to channel 1 (12'h100 then 12'h200) during another channel's ISSUE.
  - Required: exactly one channel-1 transaction, with data=12'h200.
- Write channel 0 and never pulse dacdone.
  - Required: after TIMEOUT cycles dactrig=0 and err=1; channel 0 is retried; err stays 1 after that retry's dacdone.
- Assert RST during ISSUE with channels 1 and 3 pending.
  - Required: next edge dactrig=0, pending=0, err=0, LED=0; no further transactions.
- With DAC_SCHED_BROADCAST_EN: bc_en data=12'h800 while channels 0 and 2 are pending.
  - Required: the first transaction uses address=4'hF and data=12'h800, pending clears to 0, and no channel transactions follow.
